// File: rtl/trace_ctrl_pkg.sv
// Shared types for the trace capture sequencer: state encoding and its width.
package trace_ctrl_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StArmed   = 3'd1,
    StPost    = 3'd2,
    StAlign   = 3'd3,
    StReadout = 3'd4
  } trace_state_e;

endpackage

// File: rtl/trace_trig_match.sv
// Combinational masked trigger compare; with TRACE_DEDUP_EN also flags a sample
// equal to the last word written.
module trace_trig_match #(
  parameter int unsigned TW = 32
) (
  input  logic [TW-1:0] sample_i,
  input  logic [TW-1:0] trig_mask_i,
  input  logic [TW-1:0] trig_value_i,
`ifdef TRACE_DEDUP_EN
  input  logic [TW-1:0] last_i,
  output logic          dup_o,
`endif
  output logic          match_o
);

  assign match_o = ((sample_i ^ trig_value_i) & trig_mask_i) == '0;

`ifdef TRACE_DEDUP_EN
  assign dup_o = (sample_i == last_i);
`endif

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace buffer sequencer: arm, trigger, pre/post fill, read-pointer alignment, oldest-first readout.
// Optional TRACE_DEDUP_EN suppresses writes of samples equal to the last written word.
module trace_capture_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int unsigned TW     = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              disarm,
  input  logic [TW-1:0]     trig_mask,
  input  logic [TW-1:0]     trig_value,
  input  logic [ADDR_W-1:0] post_len,
  input  logic [TW-1:0]     sample_in,
  input  logic              sample_valid,
  output logic [TW-1:0]     tb_trace,
  output logic              tb_trigger,
  output logic              tb_rd,
  input  logic              host_rd_req,
  output logic              host_rd_valid,
  output logic [ADDR_W:0]   words_avail,
  output logic [StateW-1:0] state_o,
  output logic              triggered,
  output logic              wrapped
);

  localparam logic [ADDR_W:0] FillMax = {1'b1, {ADDR_W{1'b0}}};

  trace_state_e      state_q, state_d;
  logic [ADDR_W-1:0] wr_m_q, rd_m_q, post_cnt_q, post_cnt_d, oldest;
  logic [ADDR_W:0]   fill_q, fill_d, words_q, words_d;
  logic              triggered_q, triggered_d, wrapped_q, wrapped_d;
  logic              tb_trigger_q, host_rd_valid_q;
  logic [TW-1:0]     tb_trace_q;
  logic              capture, start, match, wr_en, rd_en;

  assign capture = (state_q == StArmed) || (state_q == StPost);
  assign start   = arm && !disarm && ((state_q == StIdle) || (state_q == StReadout));

`ifdef TRACE_DEDUP_EN
  logic [TW-1:0] last_q;
  logic          have_last_q, dup;
`endif

  trace_trig_match #(
    .TW(TW)
  ) u_match (
    .sample_i    (sample_in),
    .trig_mask_i (trig_mask),
    .trig_value_i(trig_value),
`ifdef TRACE_DEDUP_EN
    .last_i      (last_q),
    .dup_o       (dup),
`endif
    .match_o     (match)
  );

`ifdef TRACE_DEDUP_EN
  assign wr_en = capture && sample_valid && !disarm && !(have_last_q && dup);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
    end else if (start) begin
      have_last_q <= 1'b0;
    end else if (wr_en) begin
      last_q      <= sample_in;
      have_last_q <= 1'b1;
    end
  end
`else
  assign wr_en = capture && sample_valid && !disarm;
`endif

  // Account for a write still in flight so the oldest word is exact on ALIGN entry.
  assign oldest = wr_m_q + ADDR_W'(tb_trigger_q) - fill_q[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    post_cnt_d  = post_cnt_q;
    fill_d      = fill_q;
    words_d     = words_q;
    triggered_d = triggered_q;
    wrapped_d   = wrapped_q;
    rd_en       = 1'b0;

    if (wr_en) begin
      if (fill_q == FillMax) wrapped_d = 1'b1;
      else                   fill_d    = fill_q + 1'b1;
    end

    case (state_q)
      StArmed: begin
        if (sample_valid && match) begin
          triggered_d = 1'b1;
          state_d     = (post_cnt_q == '0) ? StAlign : StPost;
        end
      end
      StPost: begin
        if (wr_en) begin
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == ADDR_W'(1)) state_d = StAlign;
        end
      end
      StAlign: begin
        // Discard reads never overlap the final write strobe.
        if (!tb_trigger_q) begin
          if (rd_m_q != oldest) begin
            rd_en = 1'b1;
          end else begin
            state_d = StReadout;
            words_d = fill_q;
          end
        end
      end
      StReadout: begin
        if (!arm && host_rd_req && (words_q != '0)) begin
          rd_en   = 1'b1;
          words_d = words_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (start) begin
      state_d     = StArmed;
      post_cnt_d  = post_len;
      fill_d      = '0;
      words_d     = '0;
      triggered_d = 1'b0;
      wrapped_d   = 1'b0;
    end

    if (disarm) begin
      state_d = StIdle;
      words_d = '0;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      wr_m_q          <= '0;
      rd_m_q          <= '0;
      post_cnt_q      <= '0;
      fill_q          <= '0;
      words_q         <= '0;
      triggered_q     <= 1'b0;
      wrapped_q       <= 1'b0;
      tb_trigger_q    <= 1'b0;
      tb_trace_q      <= '0;
      host_rd_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_m_q          <= wr_m_q + ADDR_W'(tb_trigger_q);
      rd_m_q          <= rd_m_q + ADDR_W'(rd_en);
      post_cnt_q      <= post_cnt_d;
      fill_q          <= fill_d;
      words_q         <= words_d;
      triggered_q     <= triggered_d;
      wrapped_q       <= wrapped_d;
      tb_trigger_q    <= wr_en;
      tb_trace_q      <= sample_in;
      host_rd_valid_q <= rd_en && (state_q == StReadout);
    end
  end

  assign tb_trace      = tb_trace_q;
  assign tb_trigger    = tb_trigger_q;
  assign tb_rd         = rd_en;
  assign host_rd_valid = host_rd_valid_q;
  assign words_avail   = words_q;
  assign state_o       = state_q;
  assign triggered     = triggered_q;
  assign wrapped       = wrapped_q;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl with a behavioural trace buffer (DEPTH=16).
module tb_trace_capture_ctrl;

  localparam int unsigned TW     = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned Depth  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm, disarm, sample_valid, host_rd_req;
  logic [TW-1:0]     trig_mask, trig_value, sample_in;
  logic [ADDR_W-1:0] post_len;
  logic [TW-1:0]     tb_trace;
  logic              tb_trigger, tb_rd, host_rd_valid, triggered, wrapped;
  logic [ADDR_W:0]   words_avail;
  logic [2:0]        state_o;

  always #5 clk = ~clk;

  trace_capture_ctrl #(
    .TW    (TW),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arm          (arm),
    .disarm       (disarm),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
    .post_len     (post_len),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .tb_trace     (tb_trace),
    .tb_trigger   (tb_trigger),
    .tb_rd        (tb_rd),
    .host_rd_req  (host_rd_req),
    .host_rd_valid(host_rd_valid),
    .words_avail  (words_avail),
    .state_o      (state_o),
    .triggered    (triggered),
    .wrapped      (wrapped)
  );

  // Trace buffer: independent write/read pointers, registered dout.
  logic [TW-1:0]     mem [Depth];
  logic [ADDR_W-1:0] bwp, brp;
  logic [TW-1:0]     bdout;

  always @(posedge clk) if (!reset && tb_trigger) mem[bwp] <= tb_trace;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bwp   <= '0;
      brp   <= '0;
      bdout <= '0;
    end else begin
      if (tb_trigger) bwp <= bwp + 1'b1;
      if (tb_rd) begin
        bdout <= mem[brp];
        brp   <= brp + 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic do_arm(input logic [ADDR_W-1:0] pl, input logic [TW-1:0] val,
                        input logic [TW-1:0] mask);
    trig_value = val;
    trig_mask  = mask;
    post_len   = pl;
    arm        = 1'b1;
    tick();
    arm      = 1'b0;
    post_len = ~pl;  // must have been latched at arm
    n_checks++;
    if (state_o !== 3'd1 || words_avail !== '0) begin
      n_fail++;
      $display("FAIL arm: state %0d words %0d, expected state 1 words 0", state_o, words_avail);
    end
  endtask

  task automatic feed(input logic [TW-1:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_readout(input int exp_disc);
    int  disc = 0;
    bit  done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (state_o == 3'd4) done = 1;
      else begin
        if (state_o == 3'd3 && tb_rd) disc++;
        tick();
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL align_timeout: state %0d expected 4", state_o);
    end
    if (exp_disc >= 0) begin
      n_checks++;
      if (disc != exp_disc) begin
        n_fail++;
        $display("FAIL discard_reads: got %0d expected %0d", disc, exp_disc);
      end
    end
    n_checks++;
    if (words_avail !== (ADDR_W+1)'(exp_q.size())) begin
      n_fail++;
      $display("FAIL words_avail_load: got %0d expected %0d", words_avail, exp_q.size());
    end
  endtask

  task automatic read_words;
    int k = 0;
    host_rd_req = 1'b1;
    for (int i = 0; i < exp_q.size() + 3; i++) begin
      n_checks++;
      if (tb_rd && tb_trigger) begin
        n_fail++;
        $display("FAIL rd_wr_overlap: tb_rd=1 tb_trigger=1 expected not both");
      end
      tick();
      if (host_rd_valid) begin
        n_checks++;
        if (k >= exp_q.size() || bdout !== exp_q[k]) begin
          n_fail++;
          $display("FAIL readout[%0d]: got %0h expected %0h", k, bdout,
                   (k < exp_q.size()) ? exp_q[k] : 32'hx);
        end
        k++;
      end
    end
    chk("words_count", 64'(k), 64'(exp_q.size()));
    chk("rd_after_empty", {62'd0, tb_rd, host_rd_valid}, 64'd0);
    chk("words_avail_empty", 64'(words_avail), 64'd0);
    host_rd_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; arm = 0; disarm = 0; sample_valid = 0; host_rd_req = 0;
    trig_mask = '0; trig_value = '0; post_len = '0; sample_in = '0;
    tick();
    chk("reset_outputs", {51'd0, state_o, tb_trigger, tb_rd, host_rd_valid, words_avail,
                          triggered, wrapped}, 64'd0);
    chk("reset_trace", 64'(tb_trace), 64'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    do_arm(4'd3, 32'd5, 32'hFFFF_FFFF);
    for (int v = 0; v < 10; v++) feed(32'(v));
    exp_q = {};
    for (int v = 0; v < 9; v++) exp_q.push_back(32'(v));
    wait_readout(0);
    chk("basic_flags", {62'd0, triggered, wrapped}, 64'd2);
    read_words();
  endtask

  task automatic test_wrap;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    do_arm(4'd2, 32'd140, 32'hFFFF_FFFF);
    for (int v = 100; v <= 142; v++) feed(32'(v));
    exp_q = {};
    for (int v = 127; v <= 142; v++) exp_q.push_back(32'(v));
    wait_readout(11);
    chk("wrap_flags", {62'd0, triggered, wrapped}, 64'd3);
    read_words();
  endtask

  task automatic test_post_zero;
    do_arm(4'd0, 32'h55, 32'hFFFF_FFFF);  // arm from READOUT restarts
    feed(32'h55);
    chk("post0_state", 64'(state_o), 64'd3);
    exp_q = {32'h55};
    wait_readout(0);
    read_words();
  endtask

  task automatic test_disarm;
    do_arm(4'd5, 32'h7, 32'hFF);
    feed(32'h6);
    chk("mask_nomatch", 64'(state_o), 64'd1);
    feed(32'hABCD_0007);
    chk("mask_match", {61'd0, state_o}, 64'd2);
    feed(32'h1);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk("disarm_idle", 64'(state_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      sample_in = 32'(i); sample_valid = 1'b1;
      tick();
      chk("no_write_after_disarm", 64'(tb_trigger), 64'd0);
    end
    sample_valid = 1'b0;
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    chk("arm_disarm_idle", 64'(state_o), 64'd0);
  endtask

  task automatic test_back_to_back;
    do_arm(4'd1, 32'h20, 32'hFFFF_FFFF);
    feed(32'h10); feed(32'h20); feed(32'h30);
    exp_q = {32'h10, 32'h20, 32'h30};
    wait_readout(3);
    host_rd_req = 1'b1;
    tick();
    host_rd_req = 1'b0;
    chk("partial_valid", 64'(host_rd_valid), 64'd1);
    chk("partial_data", 64'(bdout), 64'h10);
    chk("partial_words", 64'(words_avail), 64'd2);
    do_arm(4'd0, 32'h99, 32'hFFFF_FFFF);
    feed(32'h99);
    exp_q = {32'h99};
    wait_readout(2);
    read_words();
  endtask

  task automatic test_dedup;
    do_arm(4'd0, 32'h9, 32'hFFFF_FFFF);
    feed(32'h7); feed(32'h7); feed(32'h7); feed(32'h8); feed(32'h8); feed(32'h9);
`ifdef TRACE_DEDUP_EN
    exp_q = {32'h7, 32'h8, 32'h9};
`else
    exp_q = {32'h7, 32'h7, 32'h7, 32'h8, 32'h8, 32'h9};
`endif
    wait_readout(-1);
    read_words();
  endtask

  task automatic test_reset_mid;
    do_arm(4'd3, 32'hFFFF, 32'hFFFF_FFFF);
    sample_in = 32'h1; sample_valid = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    chk("reset_mid", {60'd0, state_o, tb_trigger}, 64'd0);
    sample_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_post_zero();
    test_disarm();
    test_back_to_back();
    test_dedup();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
